block_accumulator_writer: RTL and testbench
===========================================

# block_accumulator_writer

Downstream stage of the 2x2 base block multiplier. Accumulates successive 2x2 partial-product tiles (c11..c22) over the inner-dimension loop, then writes the finished output tile back to the single-port RAM as four sequential word writes. It removes accumulation and write-back sequencing from the control unit, which only issues `acc_valid`/`last` alongside the multiplier's `done`.

## Interface

**Parameters**
- `data_w`, 32: element width, signed two's complement.
- `addr_w`, 9: RAM address width.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `clear`, in, 1: zero all accumulators and the sticky flags; starts a new output tile.
- `acc_valid`, in, 1: one-cycle pulse; the `c_*` inputs hold a partial tile.
- `last`, in, 1: qualifies `acc_valid`; this is the final partial and write-back starts afterwards.
- `c_11`, `c_12`, `c_21`, `c_22`, in, `data_w` each: partial-product tile.
- `wb_base`, in, `addr_w`: RAM address of c11, sampled on an accepted `acc_valid` with `last`.
- `row_stride`, in, `addr_w`: words per matrix row, sampled with `wb_base`.
- `in_ready`, out, 1: the block can accept `acc_valid`.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, `addr_w`: RAM address.
- `ram_wdata`, out, `data_w`: RAM write data.
- `wb_done`, out, 1: one-cycle pulse after the fourth write.
- `ovf`, out, 1: sticky signed overflow in any accumulator.
- `proto_err`, out, 1: sticky; `acc_valid` was asserted while `in_ready` was low.

## Operation

**States**
- IDLE/ACCUM: a single accepting state, `in_ready`=1.
- WR0–WR3: write-back, `in_ready`=0.
- Transitions:
  - ACCUM → WR0 on an accepted `acc_valid && last`.
  - WRn → WRn+1.
  - WR3 → ACCUM.

**Accumulation**
- On an accepted `acc_valid`, each accumulator updates as `acc_xy <= acc_xy + c_xy`.
- Addition wraps modulo 2^`data_w`.
- `ovf` sets when the operand signs are equal and the result sign differs.

**clear**
- `clear` alone: accumulators and both sticky flags go to 0.
- `clear` together with an accepted `acc_valid`: accumulators load `c_xy` (no add) and the flags go to 0. The overflow check is skipped for that load.
- `clear` during WR0–WR3 is ignored. The write-back completes from the latched values.

**Write-back**
- Write order and addresses:
  - WR0: c11 at `base`.
  - WR1: c12 at `base+1`.
  - WR2: c21 at `base+row_stride`.
  - WR3: c22 at `base+row_stride+1`.
- All addresses wrap modulo 2^`addr_w`.
- Accumulators reset to 0 on WR3 so the next tile starts clean. Flags are not cleared by the write-back.

**Protocol error**
- `acc_valid` while `in_ready`=0 is dropped and sets `proto_err`.
- `last` without `acc_valid` is ignored.

**Reset**
- Applies at any time, including mid-write-back; the remaining writes are abandoned.
- After reset: state ACCUM, accumulators 0, `in_ready`=1, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `wb_done`=0, `ovf`=0, `proto_err`=0.

## Timing

- `acc_valid` accepted at edge t: accumulators are valid after edge t.
- With `last` at edge t:
  - `ram_we`=1 during cycles t+1..t+4, with address/data for WR0..WR3.
  - `in_ready`=0 during t+1..t+4.
  - `wb_done`=1 during cycle t+5, and `in_ready` returns to 1 in the same cycle.
- An `acc_valid` is accepted in the same cycle that `wb_done` is high.
- Throughput: one partial per cycle while accumulating. A `last` costs 4 extra cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `ram_we`, `ram_addr` and `ram_wdata` are 0 outside WR0–WR3.

## Structure

- Shared package `matmul_pkg`:
  - `DATA_W`=32, `ADDR_W`=9.
  - state enum `wb_state_t` (ACCUM, WR0..WR3).
  - a function `sadd_ovf(a, b)` returning the sum and an overflow bit.
- Natural sub-module: `sat_free_accum`, one `data_w` wrapping accumulator with an overflow flag, instantiated 4 times.
- Top level holds the FSM, address generation and the write-data mux.

## Test plan

1. **Basic accumulate and write.** After reset, `clear`, then partial tiles {1,2,3,4} and {10,20,30,40}, the second with `last`, `wb_base`=0x010, `row_stride`=8 → writes 11@0x010, 22@0x011, 33@0x018, 44@0x019 in 4 consecutive cycles, then `wb_done` for one cycle; `ovf`=0.
2. **Overflow and wrap.** Partial c11 with `acc_valid`: 0x7FFFFFFF, then 1 → acc = 0x80000000, `ovf`=1. A following `clear` → `ovf`=0.
3. **Address wrap.** `wb_base`=0x1FF, `row_stride`=1 with `last` → addresses 0x1FF, 0x000, 0x000, 0x001.
4. **Protocol error.** `acc_valid` asserted during WR1 → the pulse is dropped, `proto_err`=1, and the written data is unchanged.
5. **Clear coincident with valid.** Accumulators hold 5, then `clear`+`acc_valid` with c={7,7,7,7} → accumulators = 7 (not 12).
6. **Reset mid-write.** `rst` asserted during WR2 → next cycle `ram_we`=0, `in_ready`=1, no `wb_done`; a fresh 1-partial tile with `last` then writes the correct values.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 block matrix-multiply datapath:
// default widths, write-back state encoding and a wrapping signed add helper.
package matmul_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef enum logic [2:0] {
        ACCUM,
        WR0,
        WR1,
        WR2,
        WR3
    } wb_state_t;

    typedef struct packed {
        logic              ovf;
        logic [DATA_W-1:0] sum;
    } sadd_t;

    // Two's complement add that wraps; ovf flags a sign flip between equal-signed operands.
    function automatic sadd_t sadd_ovf(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        sadd_t r;
        r.sum = a + b;
        r.ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r.sum[DATA_W-1] != a[DATA_W-1]);
        return r;
    endfunction

endpackage

// File: rtl/sat_free_accum.sv
// One wrapping signed accumulator. acc_nxt is the value the register takes at the
// coming edge, so the write-back path can capture a tile that completes on that edge.
module sat_free_accum
    import matmul_pkg::*;
#(
    parameter int data_w = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              zero,
    input  logic [data_w-1:0] din,
    output logic [data_w-1:0] acc_nxt,
    output logic              ovf_hit
);

    logic signed [data_w-1:0] acc;

    function automatic logic [data_w:0] add_wrap(input logic signed [data_w-1:0] a,
                                                  input logic signed [data_w-1:0] b);
        logic signed [data_w-1:0] s;
        s = a + b;
        return {(a[data_w-1] == b[data_w-1]) && (s[data_w-1] != a[data_w-1]), s};
    endfunction

    // clear wins over everything; a coincident valid loads rather than adds
    always_comb begin
        acc_nxt = acc;
        ovf_hit = 1'b0;
        if (clr) begin
            acc_nxt = en ? din : '0;
        end else if (zero) begin
            acc_nxt = '0;
        end else if (en) begin
            {ovf_hit, acc_nxt} = add_wrap(acc, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/block_accumulator_writer.sv
// Accumulates 2x2 partial-product tiles and writes the finished tile back to RAM
// as four sequential word writes (c11, c12, c21, c22).
module block_accumulator_writer
    import matmul_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int addr_w = ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc_valid,
    input  logic              last,
    input  logic [data_w-1:0] c_11,
    input  logic [data_w-1:0] c_12,
    input  logic [data_w-1:0] c_21,
    input  logic [data_w-1:0] c_22,
    input  logic [addr_w-1:0] wb_base,
    input  logic [addr_w-1:0] row_stride,
    output logic              in_ready,
    output logic              ram_we,
    output logic [addr_w-1:0] ram_addr,
    output logic [data_w-1:0] ram_wdata,
    output logic              wb_done,
    output logic              ovf,
    output logic              proto_err
);

    wb_state_t         state;
    logic [addr_w-1:0] base_r;
    logic [addr_w-1:0] stride_r;

    logic              accepting;
    logic              accept;
    logic              clr_eff;
    logic              wr_end;
    logic [data_w-1:0] c_in    [4];
    logic [data_w-1:0] acc_nxt [4];
    logic [3:0]        hit;

    assign accepting = (state == ACCUM);
    assign accept    = acc_valid && accepting;
    assign clr_eff   = clear && accepting;
    assign wr_end    = (state == WR3);

    assign c_in[0] = c_11;
    assign c_in[1] = c_12;
    assign c_in[2] = c_21;
    assign c_in[3] = c_22;

    for (genvar i = 0; i < 4; i++) begin : g_acc
        sat_free_accum #(.data_w(data_w)) u_acc (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr_eff),
            .en      (accept),
            .zero    (wr_end),
            .din     (c_in[i]),
            .acc_nxt (acc_nxt[i]),
            .ovf_hit (hit[i])
        );
    end

    // RAM outputs are loaded one state ahead so each WRn cycle presents its own word;
    // accumulators are frozen during write-back, so acc_nxt equals the held value there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            wb_done   <= 1'b0;
            ovf       <= 1'b0;
            proto_err <= 1'b0;
            base_r    <= '0;
            stride_r  <= '0;
        end else begin
            wb_done   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            in_ready  <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept && last) begin
                        state     <= WR0;
                        ram_we    <= 1'b1;
                        ram_addr  <= wb_base;
                        ram_wdata <= acc_nxt[0];
                        base_r    <= wb_base;
                        stride_r  <= row_stride;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                WR0: begin
                    state     <= WR1;
                    ram_we    <= 1'b1;
                    ram_addr  <= base_r + addr_w'(1);
                    ram_wdata <= acc_nxt[1];
                end
                WR1: begin
                    state     <= WR2;
                    ram_we    <= 1'b1;
                    ram_addr  <= base_r + stride_r;
                    ram_wdata <= acc_nxt[2];
                end
                WR2: begin
                    state     <= WR3;
                    ram_we    <= 1'b1;
                    ram_addr  <= base_r + stride_r + addr_w'(1);
                    ram_wdata <= acc_nxt[3];
                end
                WR3: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                    wb_done  <= 1'b1;
                end
                default: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
            endcase

            if (clr_eff) begin
                ovf <= 1'b0;
            end else if (|hit) begin
                ovf <= 1'b1;
            end

            if (clr_eff) begin
                proto_err <= 1'b0;
            end else if (acc_valid && !accepting) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_accumulator_writer.sv
// Bench for block_accumulator_writer: directed scenarios plus random traffic
// compared every cycle against a tile-level reference model.
module tb_block_accumulator_writer;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst, clear, acc_valid, last;
    logic [DW-1:0] c_11, c_12, c_21, c_22;
    logic [AW-1:0] wb_base, row_stride;
    logic          in_ready, ram_we, wb_done, ovf, proto_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    always #5 clk = ~clk;

    block_accumulator_writer #(.data_w(DW), .addr_w(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .acc_valid  (acc_valid),
        .last       (last),
        .c_11       (c_11),
        .c_12       (c_12),
        .c_21       (c_21),
        .c_22       (c_22),
        .wb_base    (wb_base),
        .row_stride (row_stride),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .wb_done    (wb_done),
        .ovf        (ovf),
        .proto_err  (proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model: tile sums, sticky flags, and a position in the write-back
    // sequence (0 idle, 1..4 writing word pos-1, 5 done pulse).
    logic [DW-1:0] m_acc  [4];
    logic [AW-1:0] m_addr [4];
    logic [DW-1:0] m_data [4];
    bit            m_ovf, m_proto;
    int            m_pos;

    task automatic model_step();
        logic [DW-1:0] c [4];
        longint        s;
        int            off;
        c = '{c_11, c_12, c_21, c_22};
        if (rst) begin
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
            m_ovf = 0;
            m_proto = 0;
            m_pos = 0;
        end else if (m_pos >= 1 && m_pos <= 4) begin
            if (acc_valid) m_proto = 1;
            if (m_pos == 4) begin
                for (int i = 0; i < 4; i++) m_acc[i] = '0;
                m_pos = 5;
            end else begin
                m_pos++;
            end
        end else begin
            m_pos = 0;
            if (clear) begin
                for (int i = 0; i < 4; i++) m_acc[i] = acc_valid ? c[i] : '0;
                m_ovf = 0;
                m_proto = 0;
            end else if (acc_valid) begin
                for (int i = 0; i < 4; i++) begin
                    s = longint'($signed(m_acc[i])) + longint'($signed(c[i]));
                    if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
                    m_acc[i] = s[31:0];
                end
            end
            if (acc_valid && last) begin
                for (int k = 0; k < 4; k++) begin
                    off = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? int'(row_stride) : int'(row_stride) + 1;
                    m_addr[k] = AW'((int'(wb_base) + off) % 512);
                    m_data[k] = m_acc[k];
                end
                m_pos = 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit wr;
        wr = (m_pos >= 1 && m_pos <= 4);
        check("in_ready", in_ready, !wr);
        check("ram_we", ram_we, wr);
        if (wr) begin
            check("ram_addr", ram_addr, m_addr[m_pos-1]);
            check("ram_wdata", ram_wdata, m_data[m_pos-1]);
        end else begin
            check("ram_addr_idle", ram_addr, 0);
            check("ram_wdata_idle", ram_wdata, 0);
        end
        check("wb_done", wb_done, m_pos == 5);
        check("ovf", ovf, m_ovf);
        check("proto_err", proto_err, m_proto);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit l, input bit cl,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d,
                         input logic [AW-1:0] base, input logic [AW-1:0] stride);
        acc_valid  = v;
        last       = l;
        clear      = cl;
        c_11       = a;
        c_12       = b;
        c_21       = c;
        c_22       = d;
        wb_base    = base;
        row_stride = stride;
    endtask

    task automatic idle();
        acc_valid = 0;
        last      = 0;
        clear     = 0;
    endtask

    function automatic logic [DW-1:0] rand_elem();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom_range(0, 20));
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFF0 + DW'($urandom_range(0, 15))
                                                       : 32'h8000_0000 + DW'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 0;

        // basic accumulate and write
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);            tick();
        drive(1, 0, 0, 1, 2, 3, 4, 0, 0);            tick();
        drive(1, 1, 0, 10, 20, 30, 40, 9'h010, 8);   tick();
        idle();
        check("p1_addr0", ram_addr, 9'h010);
        check("p1_data0", ram_wdata, 11);
        tick();
        check("p1_addr1", ram_addr, 9'h011);
        check("p1_data1", ram_wdata, 22);
        tick();
        check("p1_addr2", ram_addr, 9'h018);
        check("p1_data2", ram_wdata, 33);
        tick();
        check("p1_addr3", ram_addr, 9'h019);
        check("p1_data3", ram_wdata, 44);
        tick();
        check("p1_done", wb_done, 1);
        check("p1_ovf", ovf, 0);

        // overflow and wrap
        drive(1, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 1, 0, 0, 0, 9'h020, 4);        tick();
        idle();
        check("p2_ovf_set", ovf, 1);
        check("p2_wrap", ram_wdata, 32'h8000_0000);
        for (int i = 0; i < 4; i++) tick();
        clear = 1;                                    tick();
        idle();
        check("p2_ovf_clr", ovf, 0);

        // address wrap
        drive(1, 1, 0, 5, 6, 7, 8, 9'h1FF, 1);        tick();
        idle();
        check("p3_addr0", ram_addr, 9'h1FF);
        tick();
        check("p3_addr1", ram_addr, 9'h000);
        tick();
        check("p3_addr2", ram_addr, 9'h000);
        tick();
        check("p3_addr3", ram_addr, 9'h001);
        tick();

        // protocol error: valid during WR1 is dropped
        drive(1, 1, 0, 3, 3, 3, 3, 9'h040, 2);        tick();
        idle();                                       tick();
        drive(1, 0, 0, 99, 99, 99, 99, 9'h040, 2);    tick();
        idle();
        check("p4_proto", proto_err, 1);
        check("p4_data", ram_wdata, 3);
        tick();
        check("p4_data3", ram_wdata, 3);
        tick();
        clear = 1;                                    tick();
        idle();

        // clear coincident with valid loads instead of adding
        drive(1, 0, 0, 5, 5, 5, 5, 0, 0);             tick();
        drive(1, 0, 1, 7, 7, 7, 7, 0, 0);             tick();
        drive(1, 1, 0, 0, 0, 0, 0, 9'h080, 16);       tick();
        idle();
        check("p5_load", ram_wdata, 7);
        for (int i = 0; i < 4; i++) tick();

        // reset during WR2 abandons the write-back
        drive(1, 1, 0, 1, 2, 3, 4, 9'h100, 4);        tick();
        idle();                                       tick();
        tick();
        rst = 1;                                      tick();
        rst = 0;
        check("p6_we", ram_we, 0);
        check("p6_ready", in_ready, 1);
        drive(1, 1, 0, 21, 22, 23, 24, 9'h030, 3);    tick();
        idle();
        check("p6_data0", ram_wdata, 21);
        check("p6_addr0", ram_addr, 9'h030);
        for (int i = 0; i < 3; i++) tick();
        check("p6_data3", ram_wdata, 24);
        check("p6_addr3", ram_addr, 9'h034);
        tick();
        check("p6_done", wb_done, 1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            acc_valid  = ($urandom_range(0, 1) != 0);
            last       = ($urandom_range(0, 4) == 0);
            clear      = ($urandom_range(0, 9) == 0);
            c_11       = rand_elem();
            c_12       = rand_elem();
            c_21       = rand_elem();
            c_22       = rand_elem();
            wb_base    = AW'($urandom);
            row_stride = AW'($urandom);
            tick();
        end
        idle();
        rst = 0;
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
